// File: rtl/axilite_noc_req_sched_pkg.sv
// Shared encodings for the AXI-lite request scheduler: message types, the
// default MSHR tag width and descriptor field widths.
package axilite_noc_req_sched_pkg;

    localparam int unsigned DEF_TAG_W  = 3;
    localparam int unsigned DEF_ADDR_W = 64;
    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned TYPE_W     = 2;

    localparam logic [TYPE_W-1:0] TYPE_LOAD  = 2'd1;
    localparam logic [TYPE_W-1:0] TYPE_STORE = 2'd2;

    // Round-robin pointer: which side wins when both channels request.
    typedef enum logic {
        RR_STORE = 1'b0,
        RR_LOAD  = 1'b1
    } rr_side_e;

endpackage

// File: rtl/axilite_tag_alloc.sv
// MSHR tag allocator: free bitmap, lowest-free priority encoder and the
// per-tag record of the message type issued on it.
module axilite_tag_alloc
    import axilite_noc_req_sched_pkg::*;
#(
    parameter int unsigned TAG_W = DEF_TAG_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alloc_en,
    input  logic [TYPE_W-1:0]         alloc_type,
    input  logic                      free_en,
    input  logic [TAG_W-1:0]          free_tag,
    output logic [TAG_W-1:0]          alloc_tag,
    output logic                      any_free,
    output logic [(1<<TAG_W)-1:0]     tag_busy,
    output logic [TYPE_W-1:0]         freed_type
);

    localparam int unsigned NUM_TAGS = 1 << TAG_W;

    logic [NUM_TAGS-1:0] busy_q, busy_d;
    logic [TYPE_W-1:0]   tag_type_q [NUM_TAGS];
    logic [TYPE_W-1:0]   tag_type_d [NUM_TAGS];

    // Encoder sees only the start-of-cycle bitmap, so a tag freed this
    // cycle cannot be handed out again until the next one.
    always_comb begin
        alloc_tag = '0;
        any_free  = 1'b0;
        for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            if (!busy_q[i] && !any_free) begin
                alloc_tag = TAG_W'(i);
                any_free  = 1'b1;
            end
        end
    end

    always_comb begin
        busy_d     = busy_q;
        tag_type_d = tag_type_q;
        if (alloc_en) begin
            busy_d[alloc_tag]     = 1'b1;
            tag_type_d[alloc_tag] = alloc_type;
        end
        if (free_en) begin
            busy_d[free_tag] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            for (int unsigned i = 0; i < NUM_TAGS; i++) begin
                tag_type_q[i] <= '0;
            end
        end else begin
            busy_q     <= busy_d;
            tag_type_q <= tag_type_d;
        end
    end

    assign tag_busy   = busy_q;
    assign freed_type = tag_type_q[free_tag];

endmodule

// File: rtl/axilite_noc_req_sched.sv
// Store/load request scheduler: round-robin arbitration, MSHR tag allocation,
// one-deep descriptor output register and completion retirement.
module axilite_noc_req_sched
    import axilite_noc_req_sched_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned TAG_W     = DEF_TAG_W,
    parameter int unsigned MAX_OUTST = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_strb,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic                  iss_valid,
    input  logic                  iss_ready,
    output logic [1:0]            iss_type,
    output logic [TAG_W-1:0]      iss_mshrid,
    output logic [ADDR_W-1:0]     iss_addr,
    output logic [DATA_W-1:0]     iss_data,
    output logic [DATA_W/8-1:0]   iss_strb,
    input  logic                  rsp_valid,
    input  logic [TAG_W-1:0]      rsp_mshrid,
    output logic                  cpl_valid,
    output logic [1:0]            cpl_type,
    output logic [TAG_W-1:0]      cpl_mshrid,
    output logic [TAG_W:0]        outst_cnt,
    output logic                  err_spurious
);

    localparam int unsigned   NUM_TAGS = 1 << TAG_W;
    localparam logic [TAG_W:0] MAX_CNT = (TAG_W+1)'(MAX_OUTST);

    logic                  can_alloc, grant_wr, grant_rd, grant, rsp_hit;
    logic [TYPE_W-1:0]     grant_type, freed_type;
    logic [TAG_W-1:0]      alloc_tag;
    logic                  any_free;
    logic [NUM_TAGS-1:0]   tag_busy;

    rr_side_e              rr_q, rr_d;
    logic                  iss_valid_q, iss_valid_d;
    logic [TYPE_W-1:0]     iss_type_q, iss_type_d;
    logic [TAG_W-1:0]      iss_mshrid_q, iss_mshrid_d;
    logic [ADDR_W-1:0]     iss_addr_q, iss_addr_d;
    logic [DATA_W-1:0]     iss_data_q, iss_data_d;
    logic [DATA_W/8-1:0]   iss_strb_q, iss_strb_d;
    logic [TAG_W:0]        outst_cnt_q, outst_cnt_d;
    logic                  cpl_valid_q, cpl_valid_d;
    logic [TYPE_W-1:0]     cpl_type_q, cpl_type_d;
    logic [TAG_W-1:0]      cpl_mshrid_q, cpl_mshrid_d;
    logic                  err_q, err_d;

    axilite_tag_alloc #(.TAG_W(TAG_W)) u_tag_alloc (
        .clk        (clk),
        .rst_n      (rst_n),
        .alloc_en   (grant),
        .alloc_type (grant_type),
        .free_en    (rsp_hit),
        .free_tag   (rsp_mshrid),
        .alloc_tag  (alloc_tag),
        .any_free   (any_free),
        .tag_busy   (tag_busy),
        .freed_type (freed_type)
    );

    always_comb begin
        can_alloc = (!iss_valid_q || iss_ready) && (outst_cnt_q < MAX_CNT) && any_free;
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        if (can_alloc) begin
            if (wr_valid && rd_valid) begin
                grant_wr = (rr_q == RR_STORE);
                grant_rd = (rr_q == RR_LOAD);
            end else begin
                grant_wr = wr_valid;
                grant_rd = rd_valid;
            end
        end
        grant      = grant_wr || grant_rd;
        grant_type = grant_wr ? TYPE_STORE : TYPE_LOAD;
        rsp_hit    = rsp_valid && tag_busy[rsp_mshrid];
    end

    always_comb begin
        rr_d         = rr_q;
        iss_valid_d  = iss_valid_q;
        iss_type_d   = iss_type_q;
        iss_mshrid_d = iss_mshrid_q;
        iss_addr_d   = iss_addr_q;
        iss_data_d   = iss_data_q;
        iss_strb_d   = iss_strb_q;
        outst_cnt_d  = outst_cnt_q;

        // Any grant points the pointer at the side that did not win.
        if (grant_wr) begin
            rr_d = RR_LOAD;
        end else if (grant_rd) begin
            rr_d = RR_STORE;
        end

        if (grant) begin
            iss_valid_d  = 1'b1;
            iss_type_d   = grant_type;
            iss_mshrid_d = alloc_tag;
            iss_addr_d   = grant_wr ? wr_addr : rd_addr;
            iss_data_d   = grant_wr ? wr_data : '0;
            iss_strb_d   = grant_wr ? wr_strb : '0;
        end else if (iss_ready) begin
            iss_valid_d  = 1'b0;
        end

        case ({grant, rsp_hit})
            2'b10:   outst_cnt_d = outst_cnt_q + (TAG_W+1)'(1);
            2'b01:   outst_cnt_d = outst_cnt_q - (TAG_W+1)'(1);
            default: outst_cnt_d = outst_cnt_q;
        endcase

        cpl_valid_d  = rsp_hit;
        cpl_type_d   = freed_type;
        cpl_mshrid_d = rsp_mshrid;
        err_d        = err_q || (rsp_valid && !rsp_hit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q         <= RR_STORE;
            iss_valid_q  <= 1'b0;
            iss_type_q   <= '0;
            iss_mshrid_q <= '0;
            iss_addr_q   <= '0;
            iss_data_q   <= '0;
            iss_strb_q   <= '0;
            outst_cnt_q  <= '0;
            cpl_valid_q  <= 1'b0;
            cpl_type_q   <= '0;
            cpl_mshrid_q <= '0;
            err_q        <= 1'b0;
        end else begin
            rr_q         <= rr_d;
            iss_valid_q  <= iss_valid_d;
            iss_type_q   <= iss_type_d;
            iss_mshrid_q <= iss_mshrid_d;
            iss_addr_q   <= iss_addr_d;
            iss_data_q   <= iss_data_d;
            iss_strb_q   <= iss_strb_d;
            outst_cnt_q  <= outst_cnt_d;
            cpl_valid_q  <= cpl_valid_d;
            cpl_type_q   <= cpl_type_d;
            cpl_mshrid_q <= cpl_mshrid_d;
            err_q        <= err_d;
        end
    end

    assign wr_ready     = grant_wr;
    assign rd_ready     = grant_rd;
    assign iss_valid    = iss_valid_q;
    assign iss_type     = iss_type_q;
    assign iss_mshrid   = iss_mshrid_q;
    assign iss_addr     = iss_addr_q;
    assign iss_data     = iss_data_q;
    assign iss_strb     = iss_strb_q;
    assign outst_cnt    = outst_cnt_q;
    assign cpl_valid    = cpl_valid_q;
    assign cpl_type     = cpl_type_q;
    assign cpl_mshrid   = cpl_mshrid_q;
    assign err_spurious = err_q;

endmodule
